// File: rtl/sccb_ov7725_slave_model_pkg.sv
// Shared definitions for the OV7725 SCCB responder model: FSM encodings,
// register addresses and the power-on register contents.
package sccb_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_DEV      = 4'd1;
  localparam state_t ST_DEV_ACK  = 4'd2;
  localparam state_t ST_SUB      = 4'd3;
  localparam state_t ST_SUB_ACK  = 4'd4;
  localparam state_t ST_WDAT     = 4'd5;
  localparam state_t ST_WDAT_ACK = 4'd6;
  localparam state_t ST_RDAT     = 4'd7;
  localparam state_t ST_RDAT_ACK = 4'd8;

  localparam logic [7:0] PID  = 8'h0A;
  localparam logic [7:0] VER  = 8'h0B;
  localparam logic [7:0] COM7 = 8'h12;
  localparam logic [7:0] MIDH = 8'h1C;
  localparam logic [7:0] MIDL = 8'h1D;

  function automatic logic [7:0] reg_default(input logic [7:0] addr);
    case (addr)
      PID:     reg_default = 8'h77;
      VER:     reg_default = 8'h21;
      MIDH:    reg_default = 8'h7F;
      MIDL:    reg_default = 8'hA2;
      default: reg_default = 8'h00;
    endcase
  endfunction

  function automatic logic is_read_only(input logic [7:0] addr);
    case (addr)
      PID, VER, MIDH, MIDL: is_read_only = 1'b1;
      default:              is_read_only = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sccb_ov7725_slave_model_if.sv
// SCCB two-wire bus seen from the camera: line levels in, open-drain SDA pull-down out.
interface sccb_ov7725_slave_model_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/sccb_ov7725_slave_model_line_sync.sv
// Two-flop synchroniser plus history stage for SCL/SDA; derives SCL edges
// and START/STOP conditions in the clk domain.
module sccb_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_lvl,
  output logic start_cond,
  output logic stop_cond
);

  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  // Idle bus is high, so the pipeline resets to ones to avoid a false START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_rise   =  scl_q[1] & ~scl_q[2];
  assign scl_fall   = ~scl_q[1] &  scl_q[2];
  assign sda_lvl    =  sda_q[1];
  assign start_cond =  scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_cond  =  scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/sccb_ov7725_slave_model.sv
// OV7725 SCCB responder: 256x8 register file, write reporting and peek port.
// Optional soft-reset emulation on COM7[7] is enabled by defining RESET_EMU_EN.
module sccb_ov7725_slave_model
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h21,
  parameter int         CNT_W        = 8,
  parameter int         RST_BUSY_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  sccb_ov7725_slave_model_if.slave      bus,
  output logic                          wr_strobe,
  output logic [7:0]                    wr_addr,
  output logic [7:0]                    wr_data,
  output logic [CNT_W-1:0]              wr_cnt,
  input  logic [7:0]                    peek_addr,
  output logic [7:0]                    peek_data,
  output logic                          busy
);

  logic scl_rise, scl_fall, sda_lvl, start_cond, stop_cond;

  sccb_line_sync u_sync (
    .clk(clk), .rst(rst), .scl_in(bus.scl_in), .sda_in(bus.sda_in),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_lvl(sda_lvl),
    .start_cond(start_cond), .stop_cond(stop_cond)
  );

  state_t             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         ptr_q, ptr_d;
  logic               rw_q, rw_d;
  logic               sda_oe_q, sda_oe_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [7:0]         wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [7:0]         peek_data_q, peek_data_d;
  logic [7:0]         mem_q [256];
  logic               mem_we, restore, busy_q;
  logic [7:0]         byte_v;

  assign byte_v = {shift_q[6:0], sda_lvl};

  // Protocol FSM: bit shifting, ACK/read-data drive and write commit.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_cnt_d    = wr_cnt_q;
    mem_we      = 1'b0;
    restore     = 1'b0;
    if (start_cond) begin
      state_d   = ST_DEV;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_cond) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_SUB, ST_WDAT: begin
          if (scl_rise) begin
            shift_d   = byte_v;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_DEV) begin
                if ((byte_v[7:1] == DEV_ADDR) && !busy_q) begin
                  state_d = ST_DEV_ACK;
                  rw_d    = byte_v[0];
                  shift_d = mem_q[ptr_q];
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_SUB) begin
                ptr_d   = byte_v;
                state_d = ST_SUB_ACK;
              end else begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = byte_v;
                ptr_d       = ptr_q + 8'd1;
                state_d     = ST_WDAT_ACK;
                if (!is_read_only(ptr_q)) begin
                  mem_we = 1'b1;
                  if (wr_cnt_q != {CNT_W{1'b1}}) begin
                    wr_cnt_d = wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                    wr_cnt_d = wr_cnt_q;
                  end
`ifdef RESET_EMU_EN
                  if ((ptr_q == COM7) && byte_v[7]) begin
                    restore = 1'b1;
                  end else begin
                    restore = 1'b0;
                  end
`endif
                end else begin
                  mem_we = 1'b0;
                end
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        // First SCL fall asserts ACK, the second ends the ACK clock.
        ST_DEV_ACK, ST_SUB_ACK, ST_WDAT_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if ((state_q == ST_DEV_ACK) && rw_q) begin
              state_d   = ST_RDAT;
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = (state_q == ST_DEV_ACK) ? ST_SUB : ST_WDAT;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RDAT: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RDAT_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RDAT_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              ptr_d   = ptr_q + 8'd1;
              shift_d = mem_q[ptr_q + 8'd1];
              state_d = ST_RDAT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_RDAT_ACK;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
    peek_data_d = mem_q[peek_addr];
  end

  // Control and reporting registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      wr_cnt_q    <= {CNT_W{1'b0}};
      peek_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_cnt_q    <= wr_cnt_d;
      peek_data_q <= peek_data_d;
    end
  end

  // Register file; peek reads the pre-write value on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst || restore) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= reg_default(8'(i));
    end else if (mem_we) begin
      mem_q[ptr_q] <= byte_v;
    end
  end

`ifdef RESET_EMU_EN
  localparam int BW = $clog2(RST_BUSY_CYC + 1);
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    if (restore) begin
      busy_cnt_d = BW'(RST_BUSY_CYC);
    end else if (busy_cnt_q != {BW{1'b0}}) begin
      busy_cnt_d = busy_cnt_q - {{(BW-1){1'b0}}, 1'b1};
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
  end

  // Soft-reset busy window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= {BW{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      busy_q     <= (busy_cnt_d != {BW{1'b0}});
    end
  end
`else
  assign busy_q = 1'b0;
`endif

  assign bus.sda_oe = sda_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_cnt     = wr_cnt_q;
  assign peek_data  = peek_data_q;
  assign busy       = busy_q;

endmodule
